conv3_sched: RTL and testbench

- Sequencer and MAC engine for the 13x13x256 conv3 layer (3x3 kernel, padding 1, stride 1), replacing the fully unrolled combinational datapath with one multiply-accumulate per cycle.
- Walks output pixels in raster order, fetches activation and kernel operands from external synchronous SRAMs, accumulates across 256 channels x 9 taps, and emits one 16-bit result per pixel over a valid/ready interface to the output buffer.

---
 rtl/conv3_pkg.sv | 23 ++
 rtl/conv3_mac.sv | 37 +++
 rtl/conv3_sched.sv | 174 +++++++++++++++++
 tb/tb_conv3_sched.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv3_pkg.sv
// conv3_pkg: geometry, FSM encoding and address types shared by the conv3 scheduler.
package conv3_pkg;
    localparam int IN_H = 13;
    localparam int IN_W = 13;
    localparam int CH   = 256;
    localparam int K    = 3;
    localparam int PAD  = 1;
    localparam int DW   = 16;

    localparam int ACT_AW = $clog2(IN_H * IN_W * CH);
    localparam int KER_AW = $clog2(K * K * CH);

    typedef logic [ACT_AW-1:0] act_addr_t;
    typedef logic [KER_AW-1:0] ker_addr_t;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        WRITE,
        DONE
    } state_e;
endpackage

// File: rtl/conv3_mac.sv
// conv3_mac: one-cycle tap valid delay feeding a truncating 16-bit multiply into a wrapping accumulator.
module conv3_mac
    import conv3_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          tap_vld,
    input  logic [DW-1:0] act,
    input  logic [DW-1:0] ker,
    output logic [DW-1:0] acc
);
    logic          vld_q, vld_d;
    logic [DW-1:0] acc_q, acc_d;

    // Operands arrive one cycle after the strobe, so the valid is delayed to line up with them.
    always_comb begin
        vld_d = tap_vld;
        acc_d = acc_q;
        if (clr)
            acc_d = '0;
        else if (vld_q)
            acc_d = acc_q + DW'(act * ker);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            acc_q <= '0;
        end else begin
            vld_q <= vld_d;
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;
endmodule

// File: rtl/conv3_sched.sv
// conv3_sched: raster-order sequencer for the 3x3 pad-1 conv3 layer, one MAC per cycle.
// Define CONV3_SKIP_PAD_EN to skip padded taps instead of issuing them with strobes low.
module conv3_sched #(
    parameter  int IN_H   = conv3_pkg::IN_H,
    parameter  int IN_W   = conv3_pkg::IN_W,
    parameter  int CH     = conv3_pkg::CH,
    localparam int DW     = conv3_pkg::DW,
    localparam int ACT_AW = $clog2(IN_H * IN_W * CH),
    localparam int KER_AW = $clog2(conv3_pkg::K * conv3_pkg::K * CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              act_rd_en,
    output logic [ACT_AW-1:0] act_addr,
    input  logic [DW-1:0]     act_rd_data,
    output logic              ker_rd_en,
    output logic [KER_AW-1:0] ker_addr,
    input  logic [DW-1:0]     ker_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_row,
    output logic [3:0]        out_col,
    output logic [DW-1:0]     out_data
);
    localparam int K   = conv3_pkg::K;
    localparam int PAD = conv3_pkg::PAD;
    localparam int CW  = (CH > 1) ? $clog2(CH) : 1;

    localparam logic [3:0]    I_LAST = 4'(IN_H - 1);
    localparam logic [3:0]    J_LAST = 4'(IN_W - 1);
    localparam logic [CW-1:0] C_LAST = CW'(CH - 1);
    localparam logic [4:0]    LO_LIM = 5'(PAD);
    localparam logic [4:0]    R_END  = 5'(IN_H + PAD);
    localparam logic [4:0]    C_END  = 5'(IN_W + PAD);

    conv3_pkg::state_e state_q, state_d;
    logic [3:0]    i_q, i_d, j_q, j_d;
    logic [CW-1:0] c_q, c_d;
    logic [1:0]    m_q, m_d, n_q, n_d;
    logic [1:0]    m_lo, m_hi, n_lo, n_hi;
    logic [4:0]    r_ext, c_ext;
    logic          tap_pad, tap_vld, acc_clr, new_pix;
    logic [DW-1:0] acc;

    // Row/column before removing the pad offset; below LO_LIM or at/after *_END is padding.
    assign r_ext   = {1'b0, i_q} + {3'b0, m_q};
    assign c_ext   = {1'b0, j_q} + {3'b0, n_q};
    assign tap_pad = (r_ext < LO_LIM) || (r_ext >= R_END) || (c_ext < LO_LIM) || (c_ext >= C_END);
    assign tap_vld = (state_q == conv3_pkg::RUN) && !tap_pad;

`ifdef CONV3_SKIP_PAD_EN
    // In-bounds taps form a rectangle, so skipping just narrows the m/n ranges.
    assign m_lo = (i_q == 4'd0)   ? 2'd1 : 2'd0;
    assign m_hi = (i_q == I_LAST) ? 2'd1 : 2'd2;
    assign n_lo = (j_q == 4'd0)   ? 2'd1 : 2'd0;
    assign n_hi = (j_q == J_LAST) ? 2'd1 : 2'd2;
`else
    assign m_lo = 2'd0;
    assign m_hi = 2'd2;
    assign n_lo = 2'd0;
    assign n_hi = 2'd2;
`endif

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        c_d     = c_q;
        m_d     = m_q;
        n_d     = n_q;
        new_pix = 1'b0;
        case (state_q)
            conv3_pkg::IDLE: begin
                if (start) begin
                    state_d = conv3_pkg::RUN;
                    i_d     = '0;
                    j_d     = '0;
                    new_pix = 1'b1;
                end
            end
            conv3_pkg::RUN: begin
                if (n_q != n_hi) begin
                    n_d = n_q + 2'd1;
                end else if (m_q != m_hi) begin
                    n_d = n_lo;
                    m_d = m_q + 2'd1;
                end else if (c_q != C_LAST) begin
                    n_d = n_lo;
                    m_d = m_lo;
                    c_d = c_q + CW'(1);
                end else begin
                    state_d = conv3_pkg::DRAIN;
                end
            end
            conv3_pkg::DRAIN: state_d = conv3_pkg::WRITE;
            conv3_pkg::WRITE: begin
                if (out_ready) begin
                    if (j_q != J_LAST) begin
                        j_d     = j_q + 4'd1;
                        state_d = conv3_pkg::RUN;
                        new_pix = 1'b1;
                    end else if (i_q != I_LAST) begin
                        j_d     = '0;
                        i_d     = i_q + 4'd1;
                        state_d = conv3_pkg::RUN;
                        new_pix = 1'b1;
                    end else begin
                        i_d     = '0;
                        j_d     = '0;
                        state_d = conv3_pkg::DONE;
                    end
                end
            end
            conv3_pkg::DONE: state_d = conv3_pkg::IDLE;
            default:         state_d = conv3_pkg::IDLE;
        endcase
        // Tap counters restart at the first tap of the pixel being entered, not the one just finished.
        if (new_pix) begin
            c_d = '0;
`ifdef CONV3_SKIP_PAD_EN
            m_d = (i_d == 4'd0) ? 2'd1 : 2'd0;
            n_d = (j_d == 4'd0) ? 2'd1 : 2'd0;
`else
            m_d = 2'd0;
            n_d = 2'd0;
`endif
        end
    end

    assign acc_clr = new_pix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= conv3_pkg::IDLE;
            i_q     <= '0;
            j_q     <= '0;
            c_q     <= '0;
            m_q     <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            c_q     <= c_d;
            m_q     <= m_d;
            n_q     <= n_d;
        end
    end

    conv3_mac u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (acc_clr),
        .tap_vld (tap_vld),
        .act     (act_rd_data),
        .ker     (ker_rd_data),
        .acc     (acc)
    );

    assign act_rd_en = tap_vld;
    assign ker_rd_en = tap_vld;
    assign act_addr  = tap_vld ? ACT_AW'(((int'(r_ext) - PAD) * IN_W + int'(c_ext) - PAD) * CH + int'(c_q)) : '0;
    assign ker_addr  = tap_vld ? KER_AW'((int'(m_q) * K + int'(n_q)) * CH + int'(c_q)) : '0;

    assign busy      = (state_q != conv3_pkg::IDLE);
    assign done      = (state_q == conv3_pkg::DONE);
    assign out_valid = (state_q == conv3_pkg::WRITE);
    assign out_row   = out_valid ? i_q : '0;
    assign out_col   = out_valid ? j_q : '0;
    assign out_data  = out_valid ? acc : '0;
endmodule

// File: tb/tb_conv3_sched.sv
// tb_conv3_sched: random-data passes over a channel-reduced conv3 layer checked against a direct convolution model.
module tb_conv3_sched;
    localparam int H = 13, W = 13, CH = 4, NPIX = H * W;
    localparam int ACT_AW = $clog2(H * W * CH);
    localparam int KER_AW = $clog2(9 * CH);
    localparam int STALL_LEN = 50;

    logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b1;
    logic              busy, done, act_rd_en, ker_rd_en, out_valid;
    logic [ACT_AW-1:0] act_addr;
    logic [KER_AW-1:0] ker_addr;
    logic [15:0]       act_rd_data, ker_rd_data, out_data;
    logic [3:0]        out_row, out_col;

    logic [15:0] act_mem [H*W*CH];
    logic [15:0] ker_mem [9*CH];
    logic [15:0] exp_data [NPIX];
    logic [15:0] got_data [NPIX];

    int checks = 0, errors = 0;
    int pix_total = 0, busy_cyc = 0, done_cnt = 0, act_reads = 0, ker_reads = 0;
    int stall_total = 0, stall_cnt = 0;
    int pass_base = 0, stall_pix = -1;
    bit rand_ready = 1'b0;
    int exp_cycles, exp_reads;
    int b_busy, b_done, b_act, b_ker, b_stall;

    conv3_sched #(.IN_H(H), .IN_W(W), .CH(CH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .act_rd_en(act_rd_en), .act_addr(act_addr), .act_rd_data(act_rd_data),
        .ker_rd_en(ker_rd_en), .ker_addr(ker_addr), .ker_rd_data(ker_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_col(out_col), .out_data(out_data)
    );

    always #5 clk = ~clk;

    // Synchronous SRAMs; unread cycles return junk so un-strobed data must never be accumulated.
    always @(posedge clk) begin
        act_rd_data <= act_rd_en ? act_mem[act_addr] : 16'($urandom);
        ker_rd_data <= ker_rd_en ? ker_mem[ker_addr] : 16'($urandom);
    end

    task automatic chk(input string nm, input logic [63:0] got_v, input logic [63:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, got_v, exp_v);
        end
    endtask

    function automatic int taps(input int i, input int j);
        int t = 0;
        for (int m = 0; m < 3; m++)
            for (int n = 0; n < 3; n++)
                if (i + m - 1 >= 0 && i + m - 1 < H && j + n - 1 >= 0 && j + n - 1 < W) t++;
        return t;
    endfunction

    function automatic logic [15:0] model(input int i, input int j);
        longint tot = 0;
        for (int m = 0; m < 3; m++)
            for (int n = 0; n < 3; n++) begin
                int r = i + m - 1;
                int q = j + n - 1;
                if (r >= 0 && r < H && q >= 0 && q < W)
                    for (int c = 0; c < CH; c++)
                        tot += (longint'(act_mem[(r*W+q)*CH+c]) * longint'(ker_mem[(m*3+n)*CH+c])) % 65536;
            end
        return 16'(tot % 65536);
    endfunction

    task automatic fill(input int mode);
        for (int a = 0; a < H*W*CH; a++)
            act_mem[a] = (mode == 0) ? 16'd1 : (mode == 1) ? 16'd256 : 16'($urandom);
        for (int a = 0; a < 9*CH; a++)
            ker_mem[a] = (mode == 0) ? 16'd1 : (mode == 1) ? 16'd256 : 16'($urandom);
        exp_cycles = 1;
        exp_reads  = 0;
        for (int p = 0; p < NPIX; p++) begin
            exp_data[p] = model(p / W, p % W);
`ifdef CONV3_SKIP_PAD_EN
            exp_cycles += taps(p / W, p % W) * CH + 2;
`else
            exp_cycles += 9 * CH + 2;
`endif
            exp_reads += taps(p / W, p % W) * CH;
        end
    endtask

    // Single compare process: picks out_ready for the coming edge, then checks what the DUT shows.
    always @(negedge clk) begin
        int pix;
        if (rst_n) begin
            pix = pix_total - pass_base;
            if (out_valid && pix == stall_pix && stall_cnt < STALL_LEN) begin
                out_ready = 1'b0;
                stall_cnt++;
            end else begin
                out_ready = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
            end
            if (busy)      busy_cyc++;
            if (done)      done_cnt++;
            if (act_rd_en) act_reads++;
            if (ker_rd_en) ker_reads++;
            if (out_valid) begin
                chk("no_reads_in_write", {act_rd_en, ker_rd_en}, 0);
                if (pix < NPIX) begin
                    chk("out_row", out_row, pix / W);
                    chk("out_col", out_col, pix % W);
                    chk("out_data", out_data, exp_data[pix]);
                    if (out_ready) begin
                        got_data[pix] = out_data;
                        pix_total++;
                    end else begin
                        stall_total++;
                    end
                end else begin
                    chk("extra_output", pix, NPIX - 1);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic begin_pass();
        tick();
        pass_base = pix_total;
        b_busy = busy_cyc; b_done = done_cnt; b_act = act_reads; b_ker = ker_reads; b_stall = stall_total;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_pass(input int budget, input int poke);
        bit seen = 1'b0;
        int k = 0;
        while (!seen && k < budget) begin
            tick();
            k++;
            start = (k == poke);
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        chk("pass_reached_done", seen, 1);
        chk("pixel_count", pix_total - pass_base, NPIX);
        chk("busy_cycles", busy_cyc - b_busy, exp_cycles + (stall_total - b_stall));
        chk("act_reads", act_reads - b_act, exp_reads);
        chk("ker_reads", ker_reads - b_ker, exp_reads);
        chk("done_pulses", done_cnt - b_done, 1);
    endtask

    initial begin
        fill(0);
        repeat (3) tick();
        chk("rst_ctrl", {busy, done, out_valid, act_rd_en, ker_rd_en}, 0);
        chk("rst_data", {out_row, out_col, out_data, act_addr, ker_addr}, 0);
        rst_n = 1'b1;

        // All ones: sums are just in-bounds tap counts times CH.
        chk("model_00", model(0, 0), 4 * CH);
        chk("model_05", model(0, 5), 6 * CH);
        chk("model_66", model(6, 6), 9 * CH);
        begin_pass();
        run_pass(20000, 0);
        chk("ones_00", got_data[0], 16);
        chk("ones_05", got_data[5], 24);
        chk("ones_66", got_data[84], 36);
        chk("ones_1212", got_data[168], 16);
        chk("ones_cycles_base", busy_cyc - b_busy, taps(0, 0) * 0 + (
`ifdef CONV3_SKIP_PAD_EN
            exp_cycles
`else
            NPIX * (9 * CH + 2) + 1
`endif
        ));

        // 256*256 truncates to zero in every product.
        fill(1);
        begin_pass();
        run_pass(20000, 0);
        chk("trunc_00", got_data[0], 0);
        chk("trunc_66", got_data[84], 0);
        chk("trunc_1212", got_data[168], 0);

        // Random data and back-pressure, a long stall at (3,4), and a start pulse while busy.
        fill(2);
        rand_ready = 1'b1;
        stall_pix  = 3 * W + 4;
        begin_pass();
        run_pass(30000, 3000);
        chk("stall_applied", stall_cnt, STALL_LEN);
        stall_pix = -1;

        // Restart in the idle cycle right after done.
        fill(2);
        begin_pass();
        run_pass(30000, 0);

        // Abort during pixel (2,2), then a clean pass from (0,0).
        fill(2);
        begin_pass();
        for (int k = 0; k < 20000 && (pix_total - pass_base) < 2 * W + 2; k++) tick();
        chk("reached_pix_22", pix_total - pass_base, 2 * W + 2);
        repeat (5) tick();
        chk("busy_before_rst", busy, 1);
        chk("rd_before_rst", act_rd_en, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", {busy, done, out_valid, act_rd_en, ker_rd_en}, 0);
        chk("midrst_data", {out_row, out_col, out_data, act_addr, ker_addr}, 0);
        tick();
        rst_n = 1'b1;
        fill(2);
        begin_pass();
        run_pass(30000, 0);
        repeat (4) tick();
        chk("no_extra_done", done_cnt - b_done, 1);
        chk("idle_at_end", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
